// File: rtl/hack_data_memory_if.sv
// Bus bundle for hack_data_memory: CPU data port, display scanner read port
// and the keyboard event handshake. The memory is the slave side.
interface hack_data_memory_if;
  logic [15:0] addressM;
  logic [15:0] outM;
  logic        writeM;
  logic [15:0] inM;
  logic [12:0] scr_addr;
  logic [15:0] scr_data;
  logic [15:0] key_code;
  logic        key_valid;
  logic        key_ready;

  modport master (
    output addressM, outM, writeM, scr_addr, key_code, key_valid,
    input  inM, scr_data, key_ready
  );

  modport slave (
    input  addressM, outM, writeM, scr_addr, key_code, key_valid,
    output inM, scr_data, key_ready
  );
endinterface

// File: rtl/hack_data_memory.sv
// Hack CPU data memory: 16K RAM, 8K screen buffer, KBD register at 0x6000.
// Asynchronous CPU read, registered read-before-write scanner port, and a
// keyboard handshake that holds each event in KBD for at least KBD_HOLD cycles.
// Optional build macro HACK_KBD_FIFO_EN adds a 4-entry keyboard event FIFO.
module hack_data_memory #(
  parameter int unsigned KBD_HOLD = 64
) (
  input  logic clk,
  input  logic reset,
  hack_data_memory_if.slave bus
);

  localparam logic [15:0] HOLD_LOAD = 16'(KBD_HOLD - 1);

  logic [15:0] ram    [0:16383];
  logic [15:0] screen [0:8191];

  logic [14:0] addr;
  logic        isRam, isScr, isKbd;
  logic        unusedAddrTop;

  logic [15:0] kbd;
  logic [15:0] holdCnt;
  logic        holdDone;
  logic        kbdLoad;
  logic [15:0] kbdNext;

  assign addr          = bus.addressM[14:0];
  assign unusedAddrTop = bus.addressM[15];
  assign isRam         = ~addr[14];
  assign isScr         = (addr[14:13] == 2'b10);
  assign isKbd         = (addr == 15'h6000);
  assign holdDone      = (holdCnt == '0);

  // CPU read path: zero-latency decode of the addressed word
  always_comb begin
    bus.inM = '0;
    if (isRam)      bus.inM = ram[addr[13:0]];
    else if (isScr) bus.inM = screen[addr[12:0]];
    else if (isKbd) bus.inM = kbd;
  end

  // CPU writes land in RAM or screen only; dropped while in reset
  always_ff @(posedge clk) begin
    if (reset && bus.writeM) begin
      if (isRam)      ram[addr[13:0]]    <= bus.outM;
      else if (isScr) screen[addr[12:0]] <= bus.outM;
    end
  end

  // Scanner port: nonblocking read sees the pre-write word on a collision
  always_ff @(posedge clk) begin
    if (!reset) bus.scr_data <= '0;
    else        bus.scr_data <= screen[bus.scr_addr];
  end

`ifdef HACK_KBD_FIFO_EN
  logic [15:0] fifo [0:3];
  logic [1:0]  wrPtr, rdPtr;
  logic [2:0]  count;
  logic        push, pop;

  // Ready comes from stored occupancy only, so a same-edge pop never frees a slot early
  assign bus.key_ready = (count != 3'd4) && reset;
  assign push          = bus.key_valid && bus.key_ready;
  assign pop           = holdDone && (count != '0);
  assign kbdLoad       = pop;
  assign kbdNext       = fifo[rdPtr];

  // FIFO storage; push is already gated off during reset through key_ready
  always_ff @(posedge clk) begin
    if (push) fifo[wrPtr] <= bus.key_code;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 2'd1;
      if (pop)  rdPtr <= rdPtr + 2'd1;
      count <= count + 3'(push) - 3'(pop);
    end
  end
`else
  assign bus.key_ready = holdDone && reset;
  assign kbdLoad       = bus.key_valid && bus.key_ready;
  assign kbdNext       = bus.key_code;
`endif

  // KBD register and its minimum-visibility hold counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      kbd     <= '0;
      holdCnt <= '0;
    end else if (kbdLoad) begin
      kbd     <= kbdNext;
      holdCnt <= HOLD_LOAD;
    end else if (!holdDone) begin
      holdCnt <= holdCnt - 16'd1;
    end
  end

endmodule
